// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states, one-cycle response.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_err.
module dmem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [31:0]   cur;
    logic          is_half;
    logic          is_word;
    logic          oor;
    logic          mis;
    logic [4:0]    lane_sh;
    logic [31:0]   mask;
    logic          err_d;
    logic [31:0]   rdata_d;
    logic [31:0]   wword_d;

    always_comb begin
        off     = addr_q - ADDR_BASE;
        idx     = off[AW+1:2];
        cur     = mem_q[idx];
        is_half = (size_q == 2'b01);
        is_word = size_q[1];
        // Below-base addresses wrap to huge offsets and fail this test too.
        oor     = (off >= SPAN);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis     = (is_half && off[0]) || (is_word && (off[1:0] != 2'b00));
`else
        mis     = 1'b0;
`endif
        err_d   = oor || mis;
        lane_sh = is_half ? {off[1], 4'b0000} : {off[1:0], 3'b000};
        mask    = 32'h0;
        rdata_d = 32'h0;
        wword_d = cur;
        unique case (1'b1)
            is_word: begin
                rdata_d = cur;
                wword_d = wdata_q;
            end
            is_half: begin
                mask    = 32'h0000_FFFF << lane_sh;
                rdata_d = {16'h0, 16'(cur >> lane_sh)};
                wword_d = (cur & ~mask) | ((wdata_q & 32'h0000_FFFF) << lane_sh);
            end
            default: begin
                mask    = 32'h0000_00FF << lane_sh;
                rdata_d = {24'h0, 8'(cur >> lane_sh)};
                wword_d = (cur & ~mask) | ((wdata_q & 32'h0000_00FF) << lane_sh);
            end
        endcase
        if (err_d || we_q) begin
            rdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        ready_q <= 1'b0;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (we_q && !err_d) begin
                        mem_q[idx] <= wword_d;
                    end
                    rdata_q <= rdata_d;
                    err_q   <= err_d;
                    valid_q <= 1'b1;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port. It accepts one load or store request at a time over a valid/ready handshake.
- Each request is translated from the CPU address space to a local word index, serviced after a fixed number of wait states, and answered with a one-cycle response pulse.
- Intended replacement for the zero-latency DMEM behind the CPU in the single-cycle-computer top level, so the multi-cycle CPU can be exercised against realistic memory latency.

Parameters:
- ADDR_BASE, 32'h10010000, CPU address mapped to local byte offset 0.
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
- WAIT_CYCLES, 2, wait states between accept and access; legal range 0..15.

Ports:
- clk_in  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_addr  input  32  CPU byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse marking a completed request.
- resp_rdata  output  32  load data, zero-extended and right-aligned; 0 for stores and errors.
- resp_err  output  1  valid only with resp_valid; 1 = request rejected.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE, wait counter=0.
- Reset does not clear the memory array. Contents are undefined until written.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch we/size/addr/wdata and drop req_ready.
  - Load the counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: decrement the counter each cycle; when the counter reaches 1, go to ACCESS.
- ACCESS:
  - Compute offset = latched addr - ADDR_BASE as 32-bit unsigned. An address below the base wraps to a large value and is therefore out of range.
  - If offset >= DEPTH_WORDS*4: no write, rdata=0, err=1.
  - Otherwise, on a store, merge into the word at offset[..:2]:
    - byte lane = offset[1:0];
    - half lane = offset[1];
    - word = full overwrite.
  - Otherwise, on a load, select the same lane, zero-extend into resp_rdata, err=0.
  - Next state is RESP.
- RESP: resp_valid=1 for exactly this cycle; next state is IDLE with req_ready=1.
- Outputs are registered. resp_rdata and resp_err hold their values until the next RESP and are meaningful only while resp_valid=1.
- Latency: accept at edge N, resp_valid high in cycle N+2+WAIT_CYCLES. Back-to-back throughput is one request per WAIT_CYCLES+3 cycles.
- req_valid and request inputs are ignored while req_ready=0; the requester holds them until accept.
- Reset asserted in any state, including mid-WAIT or ACCESS: return to IDLE next edge and drop the transaction. A store not yet past ACCESS is not written. A store whose ACCESS edge coincides with reset is also not written: reset wins.
- Misalignment (macro off): low address bits are ignored for the access size (half ignores addr[0], word ignores addr[1:0]); no error is raised.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1 or a word access with addr[1:0]!=0 completes with resp_err=1, resp_rdata=0 and no write.
  - It takes the same latency as a normal access.
  - Out-of-range takes precedence over misalignment; both set resp_err=1.
- Undefined: the alignment masking described in Behaviour applies, and resp_err reflects only range.

Test Plan:
- Reset then idle -> req_ready=1, resp_valid=0, resp_rdata=0 for 5 cycles.
- With WAIT_CYCLES=2: store word 0xDEADBEEF at 0x10010010 accepted at edge N -> resp_valid only in cycle N+4, err=0. Load word at 0x10010010 -> resp_rdata=0xDEADBEEF.
- Sub-word access after the word above:
  - store byte 0x5A to 0x10010013 -> word reads back 0x5AADBEEF;
  - load half at 0x10010012 -> 0x00005AAD;
  - load byte at 0x10010010 -> 0x000000EF.
- Range errors:
  - store to 0x1000FFFC (below base) -> resp_err=1, no write;
  - load at 0x10010000+DEPTH_WORDS*4 -> err=1, rdata=0;
  - a neighbouring valid word is unchanged.
- Reset mid-operation: store 0x12345678 to 0x10010020, assert reset during WAIT -> no resp_valid, req_ready=1 after reset, word at 0x10010020 retains its prior value.
- Load word at 0x10010022:
  - macro undefined -> returns the word at 0x10010020, err=0;
  - with DMEM_MISALIGN_TRAP_EN -> err=1, rdata=0;
  - repeat with WAIT_CYCLES=0 -> resp_valid in cycle N+2.
